// File: rtl/memory_burst_sequencer_if.sv
// Bus bundle between layer control and the memory burst sequencer.
// slave  : sequencer side (takes bases/requests, drives memory strobes and status)
// master : controller side (drives bases/requests, observes strobes and status)
//   write_address_i / read_address_i : per-channel bases, ch0 in LSBs
//   stage_finish_i / ch_sel_i        : request pulse and its channel
//   mem_wr_en_o / mem_rd_en_o        : memory enables
//   address_o / ch_o                 : memory address and active channel
//   busy_o / pending_o / done_o / overflow_o : status
interface memory_burst_sequencer_if #(
  parameter int ADDRESS_BUS_BIT_WIDTH = 32,
  parameter int NUM_CH                = 4,
  parameter int CH_SEL_WIDTH          = 2
);
  logic [NUM_CH*ADDRESS_BUS_BIT_WIDTH-1:0] write_address_i;
  logic [NUM_CH*ADDRESS_BUS_BIT_WIDTH-1:0] read_address_i;
  logic                                    stage_finish_i;
  logic [CH_SEL_WIDTH-1:0]                 ch_sel_i;
  logic                                    mem_wr_en_o;
  logic                                    mem_rd_en_o;
  logic [ADDRESS_BUS_BIT_WIDTH-1:0]        address_o;
  logic [CH_SEL_WIDTH-1:0]                 ch_o;
  logic                                    busy_o;
  logic                                    pending_o;
  logic                                    done_o;
  logic                                    overflow_o;

  modport slave (
    input  write_address_i, read_address_i, stage_finish_i, ch_sel_i,
    output mem_wr_en_o, mem_rd_en_o, address_o, ch_o,
           busy_o, pending_o, done_o, overflow_o
  );

  modport master (
    output write_address_i, read_address_i, stage_finish_i, ch_sel_i,
    input  mem_wr_en_o, mem_rd_en_o, address_o, ch_o,
           busy_o, pending_o, done_o, overflow_o
  );
endinterface

// File: rtl/memory_burst_sequencer.sv
// Memory burst sequencer: each request runs a write burst then a read burst on
// one channel. Each channel owns a write and a read offset that wrap inside a
// REGION_WORDS region; bases are latched at reset. One request may queue while
// busy; a further request while one is queued is dropped and flagged sticky.
// Ports:
//   clk         : rising-edge clock
//   layer_reset : synchronous active-high reset
//   bus         : memory_burst_sequencer_if.slave (requests, bases, enables,
//                 address, channel and status)
module memory_burst_sequencer #(
  parameter int ADDRESS_BUS_BIT_WIDTH = 32,
  parameter int NUM_CH                = 4,
  parameter int CH_SEL_WIDTH          = 2,
  parameter int PHASE_CYCLES          = 2,
  parameter int WR_BURST              = 2,
  parameter int RD_BURST              = 2,
  parameter int REGION_WORDS          = 4,
  parameter int ADDRESS_STRIDE        = 1,
  parameter int CNT_WIDTH             = 8
) (
  input  logic                    clk,
  input  logic                    layer_reset,
  memory_burst_sequencer_if.slave bus
);

  localparam int AW = ADDRESS_BUS_BIT_WIDTH;
  localparam logic [CNT_WIDTH-1:0] PH_LAST  = CNT_WIDTH'(PHASE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] WR_LAST  = CNT_WIDTH'(WR_BURST - 1);
  localparam logic [CNT_WIDTH-1:0] RD_LAST  = CNT_WIDTH'(RD_BURST - 1);
  localparam logic [CNT_WIDTH-1:0] OFF_LAST = CNT_WIDTH'(REGION_WORDS - 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_e;

  state_e                  state_q;
  logic [CH_SEL_WIDTH-1:0] ch_q;
  logic [CH_SEL_WIDTH-1:0] pend_ch_q;
  logic                    pend_q;
  logic                    ovf_q;
  logic [CNT_WIDTH-1:0]    phase_q;
  logic [CNT_WIDTH-1:0]    word_q;
  logic [CNT_WIDTH-1:0]    wr_off_q  [NUM_CH];
  logic [CNT_WIDTH-1:0]    rd_off_q  [NUM_CH];
  logic [AW-1:0]           wr_base_q [NUM_CH];
  logic [AW-1:0]           rd_base_q [NUM_CH];

  logic [CH_SEL_WIDTH-1:0] sel_ch;
  logic                    last_phase;
  logic                    final_rd;
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;

  function automatic logic [CNT_WIDTH-1:0] wrap_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == OFF_LAST) ? '0 : v + CNT_WIDTH'(1);
  endfunction

  // Out-of-range selections fall back to channel 0.
  always_comb begin
    sel_ch = '0;
    if (int'(bus.ch_sel_i) < NUM_CH) sel_ch = bus.ch_sel_i;
  end

  assign last_phase = (phase_q == PH_LAST);
  assign final_rd   = (state_q == READ) && last_phase && (word_q == RD_LAST);
  assign wr_ptr     = wr_base_q[ch_q] + AW'(wr_off_q[ch_q]) * AW'(ADDRESS_STRIDE);
  assign rd_ptr     = rd_base_q[ch_q] + AW'(rd_off_q[ch_q]) * AW'(ADDRESS_STRIDE);

  assign bus.mem_wr_en_o = (state_q == WRITE);
  assign bus.mem_rd_en_o = (state_q == READ);
  assign bus.address_o   = (state_q == READ) ? rd_ptr : wr_ptr;
  assign bus.ch_o        = ch_q;
  assign bus.busy_o      = (state_q != IDLE);
  assign bus.pending_o   = pend_q;
  assign bus.done_o      = final_rd;
  assign bus.overflow_o  = ovf_q;

  always_ff @(posedge clk) begin
    if (layer_reset) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      pend_ch_q <= '0;
      pend_q    <= 1'b0;
      ovf_q     <= 1'b0;
      phase_q   <= '0;
      word_q    <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        wr_off_q[i]  <= '0;
        rd_off_q[i]  <= '0;
        wr_base_q[i] <= bus.write_address_i[i*AW +: AW];
        rd_base_q[i] <= bus.read_address_i[i*AW +: AW];
      end
    end else begin
      // A request arriving in the final read cycle with nothing queued is
      // started directly by the READ branch below, so it never occupies pending.
      if (bus.stage_finish_i && (state_q != IDLE)) begin
        if (pend_q) begin
          ovf_q <= 1'b1;
        end else if (!final_rd) begin
          pend_q    <= 1'b1;
          pend_ch_q <= sel_ch;
        end
      end

      case (state_q)
        IDLE: begin
          if (bus.stage_finish_i) begin
            ch_q    <= sel_ch;
            state_q <= WRITE;
          end
        end
        WRITE: begin
          if (last_phase) begin
            phase_q        <= '0;
            wr_off_q[ch_q] <= wrap_inc(wr_off_q[ch_q]);
            if (word_q == WR_LAST) begin
              word_q  <= '0;
              state_q <= READ;
            end else begin
              word_q <= word_q + CNT_WIDTH'(1);
            end
          end else begin
            phase_q <= phase_q + CNT_WIDTH'(1);
          end
        end
        READ: begin
          if (last_phase) begin
            phase_q        <= '0;
            rd_off_q[ch_q] <= wrap_inc(rd_off_q[ch_q]);
            if (word_q == RD_LAST) begin
              word_q <= '0;
              if (pend_q) begin
                state_q <= WRITE;
                ch_q    <= pend_ch_q;
                pend_q  <= 1'b0;
              end else if (bus.stage_finish_i) begin
                state_q <= WRITE;
                ch_q    <= sel_ch;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              word_q <= word_q + CNT_WIDTH'(1);
            end
          end else begin
            phase_q <= phase_q + CNT_WIDTH'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
